// File: rtl/register_file.sv
// Register file: 2**ADDR_W x DATA_W, r0 hardwired to zero, two
// combinational read ports, one write port and a saturating write counter.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rs_addr, rt_addr  read indices
//   rs_data, rt_data  read data (combinational)
//   wr_en, wr_addr,   write port; commits on rising clk
//   wr_data
//   wr_count          saturating count of committed writes
//
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data
// to a matching read port.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [7:0]        r_wr_count;
  logic              w_commit;

  // A write commits only outside reset and never to r0.
  assign w_commit = wr_en && !rst && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_regs[wr_addr] <= wr_data;
      if (r_wr_count != 8'hFF) begin
        r_wr_count <= r_wr_count + 8'd1;
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = r_regs[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data = r_regs[rt_addr];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // w_commit already excludes r0 and reset.
    if (w_commit && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end
    if (w_commit && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end
`endif
  end

  assign wr_count = r_wr_count;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width; depth is 2**ADDR_W (32).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rs_addr  input  ADDR_W  read port A index.
REQ-006 SHALL have port rt_addr  input  ADDR_W  read port B index.
REQ-007 SHALL have port rs_data  output  DATA_W  read port A data.
REQ-008 SHALL have port rt_data  output  DATA_W  read port B data.
REQ-009 SHALL have port wr_en  input  1  write enable from the control unit.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write index.
REQ-011 SHALL have port wr_data  input  DATA_W  write data, driven by the writeback select (ALU result / load data / PC+4).
REQ-012 SHALL have port wr_count  output  8  saturating count of committed writes since reset.

Function
REQ-013 SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-014 SHALL update register wr_addr with wr_data on the rising clk edge when wr_en=1, rst=0 and wr_addr!=0.
REQ-015 SHALL treat register 0 as hardwired zero: writes to index 0 discarded; reads of index 0 return 0 under every condition.
REQ-016 SHALL provide combinational (zero-cycle) reads on both ports; rs_addr and rt_addr are independent and may be equal.
REQ-017 SHALL make a written value visible on a read port in the cycle following the write edge (one-cycle write-to-read latency without bypass).
REQ-018 SHALL increment wr_count by 1 on each committed write (REQ-014 conditions), saturating at 255 with no wrap.
REQ-019 SHALL not count writes to index 0 or writes blocked by rst.
REQ-020 SHALL leave all registers unchanged when wr_en=0; wr_addr and wr_data are don't-care then.

Reset
REQ-021 SHALL, on a rising clk edge with rst=1, clear all registers and wr_count to 0.
REQ-022 SHALL give rst priority over a simultaneous write; the write is lost and is not counted.
REQ-023 SHALL, after reset, drive rs_data=rt_data=0 for any address until a write commits.
REQ-024 SHALL, on rst asserted mid-stream for one cycle, discard all prior contents; writes resume on the first edge with rst=0.

Configuration
REQ-025 SHALL compile write-through bypass in when macro REGFILE_WRITE_BYPASS_EN is defined.
REQ-026 SHALL, with REGFILE_WRITE_BYPASS_EN defined, drive rs_data (rt_data) combinationally with wr_data when wr_en=1, rst=0, wr_addr!=0 and wr_addr equals rs_addr (rt_addr).
REQ-027 SHALL, without REGFILE_WRITE_BYPASS_EN, return the pre-edge stored value in the write cycle (REQ-017 latency).
REQ-028 SHALL keep the bypass from ever forwarding to index 0, and from forwarding while rst=1.

Verification
REQ-029 SHALL cover: rst=1 one edge, then read all 32 indices -> all 0, wr_count=0.
REQ-030 SHALL cover: write 0xDEADBEEF to r5, next cycle rs_addr=5, rt_addr=5 -> both 0xDEADBEEF, wr_count=1.
REQ-031 SHALL cover: write 0x12345678 to r0 -> rs_data at addr 0 stays 0, wr_count unchanged.
REQ-032 SHALL cover: r7=0x1, same cycle wr_en=1 wr_addr=7 wr_data=0x2, rs_addr=7 -> 0x1 without bypass, 0x2 with REGFILE_WRITE_BYPASS_EN; after edge, 0x2 in both builds.
REQ-033 SHALL cover: rst=1 and wr_en=1 (r3=0xAA) on same edge -> r3 reads 0, wr_count=0.
REQ-034 SHALL cover: 300 consecutive writes to r1..r31 -> wr_count=255 and holds; last value per register reads back correctly.
